// File: rtl/serializer_pkg.sv
// Shared types for the bit serializer: FSM state encoding and default width.
// SER_PARITY is only reachable when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

   typedef enum logic [1:0] {
      SER_IDLE   = 2'd0,
      SER_SHIFT  = 2'd1,
      SER_PARITY = 2'd2
   } ser_state_e;

   localparam int SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry valid/ready hold buffer in front of the serializer shifter.
// Ports: load/load_data (accept word), drain (consumer took it), data, full, ready.
module ser_hold_reg
   import serializer_pkg::*;
#(
   parameter int WIDTH = SER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             drain,
   output logic [WIDTH-1:0] data,
   output logic             full,
   output logic             ready
);

   logic [WIDTH-1:0] data_d, data_q;
   logic             full_d, full_q;
   logic             ready_d, ready_q;

   // ready is a flop so it is low throughout reset and has no
   // combinational dependence on any input.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (drain) begin
         full_d = 1'b0;
      end
      if (load) begin
         full_d = 1'b1;
         data_d = load_data;
      end
      ready_d = !full_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         full_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         full_q  <= full_d;
         ready_q <= ready_d;
      end
   end

   assign data  = data_q;
   assign full  = full_q;
   assign ready = ready_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: buffers one WIDTH-bit word, shifts MSB-first on bit_en.
// Ports: clk, reset, in_data/in_valid/in_ready, bit_en, dout, dout_valid, frame_start, busy.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH = SER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             bit_en,
   output logic             dout,
   output logic             dout_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   ser_state_e       state_d, state_q;
   logic [WIDTH-1:0] shift_d, shift_q;
   logic [CW-1:0]    cnt_d, cnt_q;
   logic             par_d, par_q;

   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             hold_ready;
   logic             hold_load;
   logic             hold_drain;
   logic             frame_done;
   logic             take;

   assign hold_load = in_valid && hold_ready;

   ser_hold_reg #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk       (clk),
      .reset     (reset),
      .load      (hold_load),
      .load_data (in_data),
      .drain     (hold_drain),
      .data      (hold_data),
      .full      (hold_full),
      .ready     (hold_ready)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      par_d      = par_q;
      frame_done = 1'b0;
      take       = 1'b0;
      hold_drain = 1'b0;

      unique case (state_q)
         SER_IDLE: begin
            take = hold_full;
         end
         SER_SHIFT: begin
            if (bit_en) begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
                  state_d = SER_PARITY;
`else
                  frame_done = 1'b1;
`endif
               end else begin
                  shift_d = {shift_q[WIDTH-2:0], 1'b0};
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         SER_PARITY: begin
`ifdef SERIALIZER_PARITY_EN
            frame_done = bit_en;
`else
            state_d = SER_IDLE;
`endif
         end
         default: begin
            state_d = SER_IDLE;
         end
      endcase

      // End of frame: chain straight into the held word when there is
      // one, so back-to-back frames have no idle bit between them.
      if (frame_done) begin
         if (hold_full) begin
            take = 1'b1;
         end else begin
            state_d = SER_IDLE;
         end
      end

      if (take) begin
         hold_drain = 1'b1;
         shift_d    = hold_data;
         cnt_d      = '0;
         par_d      = ^hold_data;
         state_d    = SER_SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SER_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
      end
   end

   always_comb begin
      dout        = 1'b0;
      dout_valid  = 1'b0;
      frame_start = 1'b0;
      unique case (state_q)
         SER_SHIFT: begin
            dout        = shift_q[WIDTH-1];
            dout_valid  = 1'b1;
            frame_start = (cnt_q == '0);
         end
         SER_PARITY: begin
            dout       = par_q;
            dout_valid = 1'b1;
         end
         default: begin
            dout = 1'b0;
         end
      endcase
   end

   assign busy     = (state_q != SER_IDLE) || hold_full;
   assign in_ready = hold_ready;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer (WIDTH=8).
// Stimulus pushes expected serial bits; a forked monitor pops on consumed bits.
module tb_bit_serializer;

   localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
   localparam int FL = W + 1;
   localparam logic LAST81 = 1'b0;
`else
   localparam int FL = W;
   localparam logic LAST81 = 1'b1;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         bit_en = 1'b1;
   logic         dout;
   logic         dout_valid;
   logic         frame_start;
   logic         busy;

   typedef struct packed {
      logic d;
      logic fs;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   bit_serializer #(
      .WIDTH(W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .bit_en      (bit_en),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .frame_start (frame_start),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic act, logic expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s got=%0b want=%0b", name, act, expv);
      end
   endtask

   task automatic chk_int(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, act, expv);
      end
   endtask

   task automatic push_word(logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) begin
         exp_q.push_back(exp_t'{d: w[i], fs: (i == W - 1)});
      end
`ifdef SERIALIZER_PARITY_EN
      exp_q.push_back(exp_t'{d: ^w, fs: 1'b0});
`endif
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && dout_valid === 1'b1 && bit_en) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_bit dout=%0b want no bit", dout);
            end else begin
               e = exp_q.pop_front();
               if (dout !== e.d || frame_start !== e.fs) begin
                  failures++;
                  $display("FAIL serial_bit got dout=%0b fs=%0b want dout=%0b fs=%0b",
                           dout, frame_start, e.d, e.fs);
               end
            end
         end
      end
   endtask

   logic [W-1:0] w3 [3];
   int           idx;
   int           nv;

   initial begin
      fork
         monitor();
      join_none

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_dout_valid", dout_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_start", frame_start, 1'b0);
      chk("rst_dout", dout, 1'b0);
      reset = 1'b0;
      tick();
      chk("ready_after_release", in_ready, 1'b1);

      // Single word A5
      in_valid = 1'b1;
      in_data = 8'hA5;
      push_word(8'hA5);
      tick();
      in_valid = 1'b0;
      chk("a5_ready_c1", in_ready, 1'b0);
      chk("a5_dv_c1", dout_valid, 1'b0);
      chk("a5_busy_c1", busy, 1'b1);
      tick();
      chk("a5_dv_c2", dout_valid, 1'b1);
      chk("a5_fs_c2", frame_start, 1'b1);
      chk("a5_dout_c2", dout, 1'b1);
      tick();
      chk("a5_fs_c3", frame_start, 1'b0);
      repeat (FL - 2) tick();
      chk("a5_dv_last", dout_valid, 1'b1);
      tick();
      chk("a5_dv_end", dout_valid, 1'b0);
      chk("a5_busy_end", busy, 1'b0);
      chk("a5_ready_end", in_ready, 1'b1);

      // Three words back-to-back, in_valid held
      w3[0] = 8'hFF;
      w3[1] = 8'h00;
      w3[2] = 8'h3C;
      in_valid = 1'b1;
      in_data = w3[0];
      push_word(w3[0]);
      idx = 1;
      for (int c = 1; c <= 3 * FL + 2; c++) begin
         tick();
         if (c == 1) chk("b2b_ready_c1", in_ready, 1'b0);
         if (c == 2) chk("b2b_ready_c2", in_ready, 1'b1);
         if (c >= 3 && c <= FL + 1) chk("b2b_ready_low", in_ready, 1'b0);
         if (c == FL + 2) chk("b2b_ready_w3", in_ready, 1'b1);
         if (c >= 2 && c <= 3 * FL + 1) chk("b2b_no_gap", dout_valid, 1'b1);
         if (c == 2 || c == FL + 2 || c == 2 * FL + 2)
            chk("b2b_fs_start", frame_start, 1'b1);
         if (c == 3 || c == FL + 1) chk("b2b_fs_mid", frame_start, 1'b0);
         if (c == 3 * FL + 2) chk("b2b_dv_end", dout_valid, 1'b0);
         if (idx == 3) begin
            in_valid = 1'b0;
         end else if (in_ready) begin
            in_data = w3[idx];
            push_word(w3[idx]);
            idx++;
         end
      end
      in_valid = 1'b0;

      // bit_en toggling, word 81
      in_valid = 1'b1;
      in_data = 8'h81;
      push_word(8'h81);
      nv = 0;
      for (int c = 1; c <= 2 * FL + 4; c++) begin
         tick();
         in_valid = 1'b0;
         bit_en = (c % 2 == 1);
         if (dout_valid) nv++;
         if (c == 3) begin
            chk("tog_dout_hold", dout, 1'b1);
            chk("tog_fs_hold", frame_start, 1'b1);
         end
         if (c == 4) chk("tog_dout_bit6", dout, 1'b0);
         if (c == 2 * FL + 1) chk("tog_dout_lastbit", dout, LAST81);
      end
      chk_int("tog_valid_cycles", nv, 2 * FL);
      bit_en = 1'b1;

      // Reset mid-frame with a second word held
      in_valid = 1'b1;
      in_data = 8'hC3;
      push_word(8'hC3);
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c == 1) in_valid = 1'b0;
         if (c == 2) begin
            chk("rmf_ready_c2", in_ready, 1'b1);
            in_valid = 1'b1;
            in_data = 8'h5A;
         end
         if (c == 3) in_valid = 1'b0;
         if (c == 4) chk("rmf_busy_held", busy, 1'b1);
         if (c == 5) reset = 1'b1;
         if (c == 6) begin
            exp_q.delete();
            chk("rmf_dv_c6", dout_valid, 1'b0);
            chk("rmf_busy_c6", busy, 1'b0);
            chk("rmf_ready_c6", in_ready, 1'b0);
            chk("rmf_dout_c6", dout, 1'b0);
         end
         if (c == 7) chk("rmf_ready_c7", in_ready, 1'b0);
         if (c == 8) reset = 1'b0;
         if (c == 9) begin
            chk("rmf_ready_rel", in_ready, 1'b1);
            chk("rmf_dv_rel", dout_valid, 1'b0);
            chk("rmf_busy_rel", busy, 1'b0);
         end
         if (c == 20) chk("rmf_dv_quiet", dout_valid, 1'b0);
      end

      // Word 07 (parity bit 1 when enabled)
      in_valid = 1'b1;
      in_data = 8'h07;
      push_word(8'h07);
      tick();
      in_valid = 1'b0;
      repeat (FL) tick();
      chk("w07_dv_last", dout_valid, 1'b1);
      tick();
      chk("w07_dv_end", dout_valid, 1'b0);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      chk_int("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
